// File: rtl/counter_mod_clkdiv_pkg.sv
// Shared types for the modulo counter: the per-edge counter operation and
// the priority decode that picks it (load > tick-up > tick-down > hold).
package counter_mod_clkdiv_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_UP   = 2'd2,
        OP_DOWN = 2'd3
    } cnt_op_e;

    // Load always wins; a tick only counts when no load is pending.
    function automatic cnt_op_e select_op(input logic load, input logic tick, input logic up_dn);
        cnt_op_e op;
        if (load) begin
            op = OP_LOAD;
        end else if (tick && up_dn) begin
            op = OP_UP;
        end else if (tick) begin
            op = OP_DOWN;
        end else begin
            op = OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/counter_mod_clkdiv_tick_gen.sv
// Prescaler: counts enabled cycles 0..DIV-1 and raises a single-cycle
// clock-enable tick on the last one. clr restarts the count from zero.
module tick_gen
    import counter_mod_clkdiv_pkg::*;
#(
    parameter int unsigned DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned      PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    // Next prescaler value: clear beats enable; hold when disabled.
    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            if (pre_q == PRE_MAX) begin
                pre_d = '0;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end else begin
            pre_d = pre_q;
        end
    end

    // Prescaler register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // Tick depends only on en and the prescaler state, never on load.
    assign tick = en && (pre_q == PRE_MAX);

endmodule

// File: rtl/counter_mod_clkdiv.sv
// Up/down modulo counter advanced by an integrated prescaler tick.
// Load clamps to MODULO-1 and restarts the prescaler; tc pulses for one
// cycle together with q taking its wrapped value.
module counter_mod_clkdiv
    import counter_mod_clkdiv_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned MODULO = 10,
    parameter int unsigned DIV    = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             tc_q;
    logic             tc_d;
    logic [WIDTH-1:0] load_clamp_s;
    logic             tick_s;
    cnt_op_e          op_s;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .tick  (tick_s)
    );

    assign op_s         = select_op(load, tick_s, up_dn);
    assign load_clamp_s = (load_val > MAX) ? MAX : load_val;

    // Next count and terminal-count flag; wraps are detected by explicit
    // compare so MODULO = 2**WIDTH still produces tc.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        case (op_s)
            OP_LOAD: begin
                cnt_d = load_clamp_s;
                tc_d  = 1'b0;
            end
            OP_UP: begin
                if (cnt_q == MAX) begin
                    cnt_d = '0;
                    tc_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                    tc_d  = 1'b0;
                end
            end
            OP_DOWN: begin
                if (cnt_q == '0) begin
                    cnt_d = MAX;
                    tc_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                    tc_d  = 1'b0;
                end
            end
            OP_HOLD: begin
                cnt_d = cnt_q;
                tc_d  = 1'b0;
            end
            default: begin
                cnt_d = cnt_q;
                tc_d  = 1'b0;
            end
        endcase
    end

    // Count and tc registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign q    = cnt_q;
    assign tc   = tc_q;
    assign tick = tick_s;

endmodule
